wb_master_bridge: RTL and testbench

WB_MASTER_BRIDGE -- requirements
Module: wb_master_bridge

---
 rtl/wb_master_bridge.sv | 131 +++++++++++++
 tb/tb_wb_master_bridge.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_bridge.sv
// Command/response to Wishbone single-transfer master bridge with a bounded
// acknowledge wait. One transaction is outstanding at a time.
module wb_master_bridge #(
    parameter int DEV_ADDR_BITS = 8,
    parameter int TIMEOUT       = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_we,
    input  logic [DEV_ADDR_BITS-3:0] cmd_addr,
    input  logic [3:0]               cmd_sel,
    input  logic [31:0]              cmd_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_data,
    output logic                     rsp_err,
    output logic                     wbm_cs_o,
    output logic [DEV_ADDR_BITS-3:0] wbm_addr_o,
    output logic [3:0]               wbm_sel_o,
    output logic [31:0]              wbm_data_o,
    output logic                     wbm_we_o,
    input  logic [31:0]              wbm_data_i,
    input  logic                     wbm_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t                     r_state;
    state_t                     w_next_state;
    logic [7:0]                 r_wait_cnt;
    logic                       r_cs;
    logic [DEV_ADDR_BITS-3:0]   r_addr;
    logic [3:0]                 r_sel;
    logic [31:0]                r_wdata;
    logic                       r_we;
    logic                       r_rsp_valid;
    logic [31:0]                r_rsp_data;
    logic                       r_rsp_err;

    logic                       w_accept;
    logic                       w_ack;
    logic                       w_timeout;

    assign w_accept  = (r_state == IDLE) && cmd_valid;
    // Ack only counts while a cycle is open; strays in IDLE/RESP fall away here.
    assign w_ack     = (r_state == BUS) && wbm_ack_i;
    assign w_timeout = (r_state == BUS) && !wbm_ack_i && (r_wait_cnt == LAST_WAIT);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (cmd_valid)              w_next_state = BUS;
            BUS:     if (w_ack || w_timeout)     w_next_state = RESP;
            RESP:    if (rsp_ready)              w_next_state = IDLE;
            default:                             w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs        <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_sel       <= '0;
            r_wdata     <= '0;
            r_wait_cnt  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            if (w_accept) begin
                r_cs       <= 1'b1;
                r_we       <= cmd_we;
                r_addr     <= cmd_addr;
                r_sel      <= cmd_sel;
                r_wdata    <= cmd_data;
                r_wait_cnt <= '0;
            end

            // cs drops on the edge that samples ack so the slave never re-acks.
            if (w_ack) begin
                r_cs        <= 1'b0;
                r_rsp_data  <= r_we ? 32'h0 : wbm_data_i;
                r_rsp_err   <= 1'b0;
                r_rsp_valid <= 1'b1;
            end else if (w_timeout) begin
                r_cs        <= 1'b0;
                r_rsp_data  <= 32'h0;
                r_rsp_err   <= 1'b1;
                r_rsp_valid <= 1'b1;
            end else if (r_state == BUS) begin
                r_wait_cnt  <= r_wait_cnt + 8'd1;
            end

            if ((r_state == RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign cmd_ready  = (r_state == IDLE) && !rst;
    assign wbm_cs_o   = r_cs;
    assign wbm_we_o   = r_we;
    assign wbm_addr_o = r_addr;
    assign wbm_sel_o  = r_sel;
    assign wbm_data_o = r_wdata;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge with a small Wishbone slave that either
// registers its ack one cycle after cs, or is driven by hand.
module tb_wb_master_bridge;

    localparam int DAB = 8;
    localparam int TO  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_we;
    logic [DAB-3:0]   cmd_addr;
    logic [3:0]       cmd_sel;
    logic [31:0]      cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_err;
    logic             wbm_cs_o;
    logic [DAB-3:0]   wbm_addr_o;
    logic [3:0]       wbm_sel_o;
    logic [31:0]      wbm_data_o;
    logic             wbm_we_o;
    logic [31:0]      wbm_data_i;
    logic             wbm_ack_i;

    logic             auto_slave;
    logic             slave_ack;
    logic             man_ack;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!auto_slave) slave_ack <= 1'b0;
        else             slave_ack <= wbm_cs_o & ~slave_ack;
    end
    assign wbm_ack_i = auto_slave ? slave_ack : man_ack;

    wb_master_bridge #(.DEV_ADDR_BITS(DAB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_sel(cmd_sel), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .wbm_cs_o(wbm_cs_o), .wbm_addr_o(wbm_addr_o), .wbm_sel_o(wbm_sel_o),
        .wbm_data_o(wbm_data_o), .wbm_we_o(wbm_we_o),
        .wbm_data_i(wbm_data_i), .wbm_ack_i(wbm_ack_i)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one command for a single edge; the bridge is expected idle.
    task automatic issue(input logic we, input logic [DAB-3:0] addr,
                         input logic [3:0] sel, input logic [31:0] data);
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_sel   = sel;
        cmd_data  = data;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Called right after the accepting edge; edges counts that edge as 1.
    task automatic wait_rsp(output int edges, output int cs_cycles, output bit ok);
        edges     = 1;
        cs_cycles = wbm_cs_o ? 1 : 0;
        ok        = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            edges++;
            if (wbm_cs_o) cs_cycles++;
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) $display("FAIL rsp_wait: no rsp_valid within 20 edges");
    endtask

    task automatic retire();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++; $display("FAIL reset_cmd_ready_in_rst: got %b expected 0", cmd_ready);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({wbm_cs_o, wbm_we_o, rsp_valid, rsp_err, cmd_ready} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_flags: got cs/we/valid/err/ready=%b expected 00001",
                     {wbm_cs_o, wbm_we_o, rsp_valid, rsp_err, cmd_ready});
        end
        checks++;
        if ({wbm_addr_o, wbm_sel_o, wbm_data_o, rsp_data} !== '0) begin
            failures++;
            $display("FAIL reset_data: addr=%h sel=%h wdata=%h rdata=%h expected all 0",
                     wbm_addr_o, wbm_sel_o, wbm_data_o, rsp_data);
        end
    endtask

    task automatic test_read();
        int edges, cs_cycles;
        bit ok;
        auto_slave = 1'b1;
        wbm_data_i = 32'hA5A5_0F0F;
        issue(1'b0, 6'h01, 4'hF, 32'h0);
        checks++;
        if ({wbm_cs_o, wbm_we_o, wbm_addr_o, wbm_sel_o, cmd_ready} !== {1'b1, 1'b0, 6'h01, 4'hF, 1'b0}) begin
            failures++;
            $display("FAIL read_bus: cs=%b we=%b addr=%h sel=%h ready=%b expected 1 0 01 f 0",
                     wbm_cs_o, wbm_we_o, wbm_addr_o, wbm_sel_o, cmd_ready);
        end
        wait_rsp(edges, cs_cycles, ok);
        checks++;
        if (!ok) failures++;
        checks++;
        if (cs_cycles !== 2) begin
            failures++; $display("FAIL read_cs_cycles: got %0d expected 2", cs_cycles);
        end
        checks++;
        if (edges !== 3) begin
            failures++; $display("FAIL read_rsp_edge: got %0d expected 3", edges);
        end
        checks++;
        if (rsp_data !== 32'hA5A5_0F0F || rsp_err !== 1'b0) begin
            failures++; $display("FAIL read_rsp: data=%h err=%b expected a5a50f0f 0", rsp_data, rsp_err);
        end
        retire();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++; $display("FAIL read_retire: valid=%b ready=%b expected 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_write();
        int edges, cs_cycles;
        bit ok;
        auto_slave = 1'b1;
        wbm_data_i = 32'hA5A5_0F0F;
        issue(1'b1, 6'h01, 4'h3, 32'h1234_5678);
        checks++;
        if ({wbm_cs_o, wbm_we_o, wbm_sel_o, wbm_data_o} !== {1'b1, 1'b1, 4'h3, 32'h1234_5678}) begin
            failures++;
            $display("FAIL write_bus: cs=%b we=%b sel=%h wdata=%h expected 1 1 3 12345678",
                     wbm_cs_o, wbm_we_o, wbm_sel_o, wbm_data_o);
        end
        wait_rsp(edges, cs_cycles, ok);
        checks++;
        if (!ok || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin
            failures++; $display("FAIL write_rsp: ok=%b data=%h err=%b expected 1 0 0", ok, rsp_data, rsp_err);
        end
        retire();
    endtask

    task automatic test_timeout();
        int edges, cs_cycles;
        bit ok;
        auto_slave = 1'b0;
        man_ack    = 1'b0;
        wbm_data_i = 32'hFFFF_FFFF;
        issue(1'b0, 6'h02, 4'hF, 32'h0);
        wait_rsp(edges, cs_cycles, ok);
        checks++;
        if (cs_cycles !== 4) begin
            failures++; $display("FAIL timeout_cs_cycles: got %0d expected 4", cs_cycles);
        end
        checks++;
        if (!ok || rsp_err !== 1'b1 || rsp_data !== 32'h0) begin
            failures++; $display("FAIL timeout_rsp: ok=%b err=%b data=%h expected 1 1 0", ok, rsp_err, rsp_data);
        end
        retire();
    endtask

    task automatic test_ack_on_timeout();
        auto_slave = 1'b0;
        man_ack    = 1'b0;
        wbm_data_i = 32'hDEAD_BEEF;
        issue(1'b0, 6'h03, 4'hF, 32'h0);
        tick(); tick(); tick();
        checks++;
        if (wbm_cs_o !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++; $display("FAIL race_pre: cs=%b valid=%b expected 1 0", wbm_cs_o, rsp_valid);
        end
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        checks++;
        if ({wbm_cs_o, rsp_valid, rsp_err} !== 3'b010 || rsp_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL race_rsp: cs=%b valid=%b err=%b data=%h expected 0 1 0 deadbeef",
                     wbm_cs_o, rsp_valid, rsp_err, rsp_data);
        end
        retire();
    endtask

    task automatic test_backpressure();
        int edges, cs_cycles;
        bit ok;
        auto_slave = 1'b1;
        wbm_data_i = 32'h0BAD_F00D;
        issue(1'b0, 6'h04, 4'hF, 32'h0);
        wait_rsp(edges, cs_cycles, ok);
        auto_slave = 1'b0;
        for (int i = 0; i < 5; i++) begin
            man_ack = (i == 2);
            tick();
            checks++;
            if ({rsp_valid, rsp_err, cmd_ready, wbm_cs_o} !== 4'b1000 || rsp_data !== 32'h0BAD_F00D) begin
                failures++;
                $display("FAIL hold_%0d: valid=%b err=%b ready=%b cs=%b data=%h expected 1 0 0 0 0badf00d",
                         i, rsp_valid, rsp_err, cmd_ready, wbm_cs_o, rsp_data);
            end
        end
        man_ack   = 1'b0;
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = 6'h3F;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready, wbm_cs_o} !== 3'b010) begin
            failures++;
            $display("FAIL retire_no_accept: valid=%b ready=%b cs=%b expected 0 1 0",
                     rsp_valid, cmd_ready, wbm_cs_o);
        end
    endtask

    task automatic test_reset_mid_bus();
        auto_slave = 1'b0;
        man_ack    = 1'b0;
        wbm_data_i = 32'h5555_AAAA;
        issue(1'b0, 6'h05, 4'hF, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (wbm_cs_o !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++; $display("FAIL midrst_edge: cs=%b valid=%b expected 0 0", wbm_cs_o, rsp_valid);
        end
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        tick();
        checks++;
        if ({wbm_cs_o, rsp_valid, rsp_err, cmd_ready} !== 4'b0001 || wbm_addr_o !== 6'h00) begin
            failures++;
            $display("FAIL midrst_late_ack: cs=%b valid=%b err=%b ready=%b addr=%h expected 0 0 0 1 00",
                     wbm_cs_o, rsp_valid, rsp_err, cmd_ready, wbm_addr_o);
        end
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_we     = 1'b0;
        cmd_addr   = '0;
        cmd_sel    = '0;
        cmd_data   = '0;
        rsp_ready  = 1'b0;
        wbm_data_i = '0;
        auto_slave = 1'b0;
        man_ack    = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_ack_on_timeout();
        test_backpressure();
        test_reset_mid_bus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
